// File: rtl/incr_sched_pkg.sv
// rtl/incr_sched_pkg.sv - shared types, defaults and helpers for the increment scheduler
package incr_sched_pkg;

  // Controller phases: wait for a request, run the adder, hand the result back
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    RESPOND = 2'd2
  } sched_state_t;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_STEP    = 1;
  localparam int DEF_CNT_W   = 16;

  // Index width for n items; never zero so a 1-entry arbiter still has a port
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin priority picker
module rr_pick
  import incr_sched_pkg::*;
#(
  parameter int N  = DEF_NUM_REQ,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_grant,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          any_req
);

  logic [IW-1:0] pos;

  // Search upward from the slot after last_grant, wrapping, first set bit wins
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_req   = 1'b0;
    pos       = '0;
    for (int k = 1; k <= N; k++) begin
      pos = IW'((int'(last_grant) + k) % N);
      if (!any_req && req[pos]) begin
        any_req    = 1'b1;
        grant[pos] = 1'b1;
        grant_idx  = pos;
      end
    end
  end

endmodule

// File: rtl/incr_rr_scheduler.sv
// rtl/incr_rr_scheduler.sv - round-robin sharing of one registered increment datapath
module incr_rr_scheduler
  import incr_sched_pkg::*;
#(
  parameter int                NUM_REQ = DEF_NUM_REQ,
  parameter int                DATA_W  = DEF_DATA_W,
  parameter logic [DATA_W-1:0] STEP    = DATA_W'(DEF_STEP),
  parameter int                CNT_W   = DEF_CNT_W,
  localparam int               IW      = idx_w(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        rsp_valid,
  input  logic [NUM_REQ-1:0]        rsp_ready,
  output logic [DATA_W-1:0]         rsp_data,
  output logic [IW-1:0]             grant_id,
  output logic                      busy,
  output logic [CNT_W-1:0]          txn_count
);

  sched_state_t        state;
  sched_state_t        next_state;
  logic [IW-1:0]       last_grant;
  logic [DATA_W-1:0]   operand;
  logic [NUM_REQ-1:0]  pick_grant;
  logic [IW-1:0]       pick_idx;
  logic                pick_any;
  logic                accept;
  logic                rsp_fire;

  rr_pick #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_pick (
    .req        (req_valid),
    .last_grant (last_grant),
    .grant      (pick_grant),
    .grant_idx  (pick_idx),
    .any_req    (pick_any)
  );

  assign accept   = (state == IDLE) && pick_any;
  assign rsp_fire = (state == RESPOND) && rsp_ready[grant_id];

  // State register; reset aborts any transaction in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state: one cycle in COMPUTE, RESPOND waits for the owner's rsp_ready
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (pick_any) next_state = COMPUTE;
      COMPUTE: next_state = RESPOND;
      RESPOND: if (rsp_ready[grant_id]) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Outputs: accept only in IDLE and never while reset is held; respond only to the owner
  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    busy      = (state != IDLE);
    if (state == IDLE && !rst) begin
      req_ready = pick_grant;
    end
    if (state == RESPOND) begin
      rsp_valid[grant_id] = 1'b1;
    end
  end

  // Datapath: capture the winner's operand, then register operand + STEP (wraps)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      operand  <= '0;
      grant_id <= '0;
      rsp_data <= '0;
    end else begin
      if (accept) begin
        operand  <= req_data[pick_idx*DATA_W +: DATA_W];
        grant_id <= pick_idx;
      end
      if (state == COMPUTE) begin
        rsp_data <= operand + STEP;
      end
    end
  end

  // Fairness pointer and completion counter move only on a finished response
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= IW'(NUM_REQ - 1);
      txn_count  <= '0;
    end else if (rsp_fire) begin
      last_grant <= grant_id;
      txn_count  <= txn_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_incr_rr_scheduler.sv
// tb/tb_incr_rr_scheduler.sv - scoreboard bench for incr_rr_scheduler
module tb_incr_rr_scheduler;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int CW = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0]    rsp_valid;
  logic [N-1:0]    rsp_ready = '0;
  logic [DW-1:0]   rsp_data;
  logic [1:0]      grant_id;
  logic            busy;
  logic [CW-1:0]   txn_count;

  incr_rr_scheduler #(
    .NUM_REQ (N),
    .DATA_W  (DW),
    .STEP    (32'd1),
    .CNT_W   (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .grant_id  (grant_id),
    .busy      (busy),
    .txn_count (txn_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            id;
    logic [DW-1:0] data;
    int            gap;
  } exp_t;

  exp_t          exp_q[$];
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  int            last_hs = 0;
  logic [CW-1:0] exp_txn = '0;
  logic [N-1:0]  keep = '0;
  logic [N-1:0]  acc;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic raise(input int i, input logic [DW-1:0] d);
    req_data[i*DW +: DW] = d;
    req_valid[i] = 1'b1;
  endtask

  task automatic expect_rsp(input int id, input logic [DW-1:0] d, input int gap);
    exp_t e;
    e.id   = id;
    e.data = d;
    e.gap  = gap;
    exp_q.push_back(e);
  endtask

  task automatic drain();
    bit done = 1'b0;
    for (int k = 0; k < 300 && !done; k++) begin
      tick();
      if (exp_q.size() == 0 && !busy && req_valid == '0) done = 1'b1;
    end
    check("drain_done", done, 1);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Requester model: drop valid after acceptance unless the requester keeps asking
  always begin
    @(negedge clk);
    acc = req_valid & req_ready;
    @(posedge clk);
    #1;
    req_valid = req_valid & ~(acc & ~keep);
  end

  // Monitor: protocol rules every cycle, scoreboard pop on each response handshake
  always begin
    exp_t e;
    @(negedge clk);
    if (rst) begin
      exp_txn = '0;
    end else begin
      check("proto_req_ready_onehot", $onehot0(req_ready), 1);
      check("proto_rsp_valid_onehot", $onehot0(rsp_valid), 1);
      if (busy) check("proto_req_ready_busy", req_ready, 0);
      check("txn_count", txn_count, exp_txn);
      if ((rsp_valid & rsp_ready) != '0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_rsp", rsp_valid, 0);
        end else begin
          e = exp_q.pop_front();
          check("rsp_id", rsp_valid, 64'(1) << e.id);
          check("rsp_grant_id", grant_id, e.id);
          check("rsp_data", rsp_data, e.data);
          if (e.gap > 0) check("rsp_gap", cyc - last_hs, e.gap);
        end
        last_hs = cyc;
        exp_txn = exp_txn + 1'b1;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not reach its end");
    $fatal(1, "watchdog");
  end

  initial begin
    bit rr_done;

    // Reset state, with a request already pending to show req_ready gating
    req_valid = 4'b0100;
    req_data[2*DW +: DW] = 32'd9;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_grant_id", grant_id, 0);
    check("rst_txn_count", txn_count, 0);
    check("rst_rsp_data", rsp_data, 0);
    req_valid = '0;
    tick();
    rst = 1'b0;

    // Single requester: 5 -> 6, latency checks
    raise(0, 32'd5);
    rsp_ready = '1;
    expect_rsp(0, 32'd6, 0);
    @(negedge clk);
    check("t1_req_ready", req_ready, 4'b0001);
    tick();
    @(negedge clk);
    check("t1_compute_busy", busy, 1);
    check("t1_compute_rsp_valid", rsp_valid, 0);
    tick();
    @(negedge clk);
    check("t1_respond_valid", rsp_valid, 4'b0001);
    drain();
    check("t1_txn", txn_count, 1);

    // Round-robin with all requesters continuously valid: order 0,1,2,3,0
    apply_reset();
    keep = '1;
    for (int i = 0; i < N; i++) raise(i, 32'(i * 10));
    expect_rsp(0, 32'd1, 0);
    expect_rsp(1, 32'd11, 3);
    expect_rsp(2, 32'd21, 3);
    expect_rsp(3, 32'd31, 3);
    expect_rsp(0, 32'd1, 3);
    rr_done = 1'b0;
    for (int k = 0; k < 100 && !rr_done; k++) begin
      tick();
      if (exp_q.size() == 0) rr_done = 1'b1;
    end
    keep = '0;
    req_valid = '0;
    check("rr_done", rr_done, 1);
    drain();

    // Backpressure on requester 2 while 3 waits; other rsp_ready bits ignored
    raise(2, 32'd100);
    raise(3, 32'd200);
    rsp_ready = 4'b1011;
    expect_rsp(2, 32'd101, 0);
    expect_rsp(3, 32'd201, 3);
    tick();
    tick();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_rsp_valid", rsp_valid, 4'b0100);
      check("bp_rsp_data", rsp_data, 32'd101);
      check("bp_req_ready", req_ready, 0);
      tick();
    end
    rsp_ready = '1;
    tick();
    @(negedge clk);
    check("bp_release_req_ready", req_ready, 4'b1000);
    drain();

    // Operand wrap
    raise(1, 32'hFFFF_FFFF);
    expect_rsp(1, 32'd0, 0);
    drain();

    // Counter wrap: 8 done since last reset, 7 more reach 15, one more wraps to 0
    for (int k = 0; k < 7; k++) begin
      raise(k % N, 32'(k * 3));
      expect_rsp(k % N, 32'(k * 3 + 1), 0);
      drain();
    end
    check("txn_pre_wrap", txn_count, 15);
    raise(2, 32'd50);
    expect_rsp(2, 32'd51, 0);
    drain();
    check("txn_wrap", txn_count, 0);

    // Reset during RESPOND: response is dropped, pointer restarts at requester 0
    rsp_ready = '0;
    raise(2, 32'd7);
    tick();
    tick();
    @(negedge clk);
    check("abort_rsp_valid_pre", rsp_valid, 4'b0100);
    #2;
    rst = 1'b1;
    #1;
    check("abort_rsp_valid", rsp_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_txn", txn_count, 0);
    raise(1, 32'd40);
    raise(3, 32'd60);
    #1;
    check("abort_req_ready", req_ready, 0);
    tick();
    tick();
    rst = 1'b0;
    rsp_ready = '1;
    expect_rsp(1, 32'd41, 0);
    expect_rsp(3, 32'd61, 3);
    @(negedge clk);
    check("post_rst_req_ready", req_ready, 4'b0010);
    drain();

    // Requester 0 re-requests as its response completes; waiting requester 1 goes first
    raise(0, 32'd1000);
    expect_rsp(0, 32'd1001, 0);
    expect_rsp(1, 32'd2001, 3);
    expect_rsp(0, 32'd3001, 3);
    tick();
    raise(1, 32'd2000);
    tick();
    raise(0, 32'd3000);
    tick();
    @(negedge clk);
    check("rereq_pick", req_ready, 4'b0010);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/incr_rr_scheduler.md
Name: incr_rr_scheduler

Overview:
Shares one registered increment datapath (out = in + STEP) between NUM_REQ requesters.
- Requesters use valid/ready handshakes on both the request and response sides.
- A round-robin arbiter picks one requester at a time; the block computes its result and returns it to that same requester.
- It sits between the requester loops and the single increment unit, so no requester needs a private adder.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
DATA_W, 32, operand/result width in bits
STEP, 1, constant added to the operand (DATA_W bits, unsigned)
CNT_W, 16, width of completed-transaction counter

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
req_valid  input  NUM_REQ  per-requester operand valid
req_ready  output  NUM_REQ  per-requester accept, one-hot or zero
req_data  input  NUM_REQ*DATA_W  packed operands, requester i at bits [i*DATA_W +: DATA_W]
rsp_valid  output  NUM_REQ  per-requester result valid, one-hot or zero
rsp_ready  input  NUM_REQ  per-requester result accept
rsp_data  output  DATA_W  result, shared by all requesters, meaningful only where rsp_valid set
grant_id  output  $clog2(NUM_REQ)  index of requester currently owning the datapath
busy  output  1  high in COMPUTE or RESPOND
txn_count  output  CNT_W  completed response handshakes, wraps mod 2^CNT_W

Behaviour:
- Reset (async assert; deassert is synchronous to clk):
  - state=IDLE; rsp_valid=0, rsp_data=0, grant_id=0, busy=0, txn_count=0.
  - Round-robin pointer last_grant=NUM_REQ-1, so requester 0 wins first.
  - req_ready is combinational and therefore 0 while rst is high.
- FSM states IDLE, COMPUTE, RESPOND:
  - IDLE: if any req_valid, winner = first set bit searching from last_grant+1 upward, wrapping mod NUM_REQ.
    - req_ready[winner]=1 combinationally in the same cycle; all other req_ready bits are 0.
    - At the edge: capture req_data[winner] and grant_id<=winner, then go to COMPUTE.
    - No req_valid: stay in IDLE, all req_ready=0.
  - COMPUTE: rsp_data <= captured + STEP, truncated to DATA_W (wraps, no overflow flag); go to RESPOND.
  - RESPOND: rsp_valid[grant_id]=1, held stable with rsp_data until rsp_ready[grant_id]=1.
    - On that edge: last_grant<=grant_id, txn_count+=1, rsp_valid<=0, go to IDLE.
    - rsp_ready bits of other requesters are ignored.
- req_ready is never asserted outside IDLE; all requests wait while busy.
- Latency:
  - Request accepted at edge T; rsp_valid rises after edge T+1 (registered); earliest response handshake at edge T+2.
  - Next request accepted no earlier than edge T+3, so peak throughput is 1 transaction / 3 cycles.
- Requester rules:
  - req_valid must not depend combinationally on req_ready.
  - Once raised, req_valid/req_data are held until accepted.
  - Bench flags a violation; block behaviour is not defined for it.
- Fairness: a continuously valid requester is served within NUM_REQ transactions.
- Simultaneous events: a requester may raise req_valid in the same cycle its own response completes; it is eligible at the next IDLE but has lowest priority there.
- Reset mid-transaction: the captured operand and any pending response are discarded; no rsp_valid after reset. txn_count excludes aborted transactions.
- Wrap: operand 2^DATA_W-1 with STEP=1 gives rsp_data=0. txn_count wraps 2^CNT_W-1 -> 0.

Decomposition:
- Package incr_sched_pkg:
  - state enum (IDLE, COMPUTE, RESPOND)
  - default constants for NUM_REQ, DATA_W, STEP
  - function idx_w(n) = max(1, $clog2(n))
- Sub-module rr_pick:
  - Combinational round-robin priority picker.
  - Inputs: req vector, last_grant.
  - Outputs: one-hot grant, grant index, any_req.
  - Instantiated once; reused by other arbiters in the design.

Test Plan:
- Single requester: reset, req_valid[0]=1 data=5, rsp_ready[0]=1 -> req_ready[0] for 1 cycle, rsp_valid[0] 2 cycles later with rsp_data=6, txn_count=1.
- Round-robin: all 4 req_valid held, data i*10, rsp_ready all 1 -> service order 0,1,2,3,0; rsp_data 1,11,21,31; each response 3 cycles apart; grant_id matches.
- Backpressure: rsp_ready[2]=0 for 5 cycles during requester 2's response -> rsp_valid[2] and rsp_data held stable; req_ready stays all 0; completes 1 cycle after rsp_ready rises.
- Wrap: data=32'hFFFF_FFFF, STEP=1 -> rsp_data=0. Separately preload 65535 transactions -> txn_count reads 0 after next.
- Reset mid-op: assert rst in RESPOND asynchronously mid-cycle -> rsp_valid drops immediately, state IDLE, txn_count=0. After release with req_valid[1],[3] set, requester 1 is served first.
- Simultaneous re-request: requester 0 completes and re-raises valid while requester 1 is waiting -> requester 1 granted next, then requester 0.
